// File: rtl/stream_mux_rr.sv
`default_nettype none
// ============================================================================
//  Module   : stream_mux_rr
//  Brief    : N-input valid/ready stream multiplexer with a single registered
//             output slot. Channel choice is either fixed (sel) or
//             round-robin with a rotating priority pointer.
//  Revision : 1.0 - initial release
// ============================================================================
module stream_mux_rr #(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  localparam int SELW = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rr_mode,
  input  logic [SELW-1:0]    sel,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [SELW-1:0]    out_chan,
  output logic               out_valid,
  input  logic               out_ready
);

  // Round-robin pointer: the lowest index that has priority this cycle.
  logic [SELW-1:0]  r_ptr;

  logic [WIDTH-1:0] w_chan_data [N];
  logic [N-1:0]     w_grant;
  logic [SELW-1:0]  w_gidx;
  logic             w_slot_free;
  logic             w_xfer;
  logic [N-1:0]     w_masked;
  logic             w_found_hi;
  logic             w_found_lo;
  logic [SELW-1:0]  w_idx_hi;
  logic [SELW-1:0]  w_idx_lo;
  logic [WIDTH-1:0] w_sel_data;

  // Unpack the flat input bus into one word per channel.
  for (genvar i = 0; i < N; i++) begin : g_chan
    assign w_chan_data[i] = in_data[i*WIDTH +: WIDTH];
  end

  assign w_slot_free = !out_valid || out_ready;

  // Grant selection. Round-robin uses two priority searches: first over the
  // requests at or above the pointer, then (if none) over all requests, which
  // is equivalent to a circular search starting at ptr.
  always_comb begin
    w_grant    = '0;
    w_gidx     = '0;
    w_masked   = '0;
    w_found_hi = 1'b0;
    w_found_lo = 1'b0;
    w_idx_hi   = '0;
    w_idx_lo   = '0;
    for (int i = 0; i < N; i++) begin
      w_masked[i] = in_valid[i] && (i >= int'(r_ptr));
    end
    for (int i = 0; i < N; i++) begin
      if (w_masked[i] && !w_found_hi) begin
        w_found_hi = 1'b1;
        w_idx_hi   = SELW'(i);
      end
      if (in_valid[i] && !w_found_lo) begin
        w_found_lo = 1'b1;
        w_idx_lo   = SELW'(i);
      end
    end
    if (rr_mode) begin
      if (w_found_hi) begin
        w_gidx           = w_idx_hi;
        w_grant[w_idx_hi] = 1'b1;
      end else if (w_found_lo) begin
        w_gidx           = w_idx_lo;
        w_grant[w_idx_lo] = 1'b1;
      end
    end else if (int'(sel) < N) begin
      if (in_valid[sel]) begin
        w_gidx       = sel;
        w_grant[sel] = 1'b1;
      end
    end
  end

  // Ready only toward the granted channel, only when the slot can accept,
  // and never while reset is asserted.
  assign in_ready = (w_slot_free && !rst) ? w_grant : '0;
  assign w_xfer   = |in_ready;

  // Data of the granted channel.
  always_comb begin
    w_sel_data = '0;
    for (int i = 0; i < N; i++) begin
      if (w_grant[i]) w_sel_data = w_chan_data[i];
    end
  end

  // Output slot and pointer: load on input transfer, drain on output accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      r_ptr     <= '0;
    end else if (w_xfer) begin
      out_valid <= 1'b1;
      out_data  <= w_sel_data;
      out_chan  <= w_gidx;
      if (rr_mode) begin
        r_ptr <= (w_gidx == SELW'(N-1)) ? '0 : w_gidx + 1'b1;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_stream_mux_rr.sv
`default_nettype none
// ============================================================================
//  Module   : tb_stream_mux_rr
//  Brief    : Scoreboard testbench for stream_mux_rr (WIDTH=8, N=4).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_stream_mux_rr;

  localparam int WIDTH = 8;
  localparam int N     = 4;
  localparam int SELW  = $clog2(N);

  logic               clk = 1'b0;
  logic               rst;
  logic               rr_mode;
  logic [SELW-1:0]    sel;
  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_valid;
  logic [N-1:0]       in_ready;
  logic [WIDTH-1:0]   out_data;
  logic [SELW-1:0]    out_chan;
  logic               out_valid;
  logic               out_ready;

  typedef struct {
    logic [WIDTH-1:0] d;
    int               c;
  } item_t;

  item_t scb[$];
  int    n_cmp = 0;
  int    n_err = 0;
  int    m_ptr = 0;
  bit    m_valid = 1'b0;

  stream_mux_rr #(.WIDTH(WIDTH), .N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .rr_mode   (rr_mode),
    .sel       (sel),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_chan  (out_chan),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  // Reference model: computes the expected grant from the arbitration rules,
  // checks in_ready/out_valid and pushes every accepted word to the scoreboard.
  always @(negedge clk) begin : model
    int          g;
    logic [N-1:0] exp_rdy;
    item_t       it;
    g = -1;
    if (!rst) begin
      if (!rr_mode) begin
        if (int'(sel) < N && in_valid[sel]) g = int'(sel);
      end else begin
        for (int k = 0; k < N; k++)
          if (g < 0 && in_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      end
    end
    exp_rdy = '0;
    if (!rst && g >= 0 && (!m_valid || out_ready)) exp_rdy[g] = 1'b1;
    n_cmp++;
    if (in_ready !== exp_rdy) begin
      n_err++;
      $display("FAIL in_ready t=%0t got %b want %b", $time, in_ready, exp_rdy);
    end
    n_cmp++;
    if (out_valid !== m_valid) begin
      n_err++;
      $display("FAIL out_valid t=%0t got %b want %b", $time, out_valid, m_valid);
    end
    if (rst) begin
      m_valid = 1'b0;
      m_ptr   = 0;
      scb.delete();
    end else if (exp_rdy != '0) begin
      it.d = in_data[g*WIDTH +: WIDTH];
      it.c = g;
      scb.push_back(it);
      m_valid = 1'b1;
      if (rr_mode) m_ptr = (g + 1) % N;
    end else if (out_ready) begin
      m_valid = 1'b0;
    end
  end

  // Monitor: every word accepted downstream must match the scoreboard head.
  always @(negedge clk) begin : monitor
    item_t e;
    if (!rst && out_valid && out_ready) begin
      n_cmp++;
      if (scb.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_output t=%0t got data=%h chan=%0d want none", $time, out_data, out_chan);
      end else begin
        e = scb.pop_front();
        if (out_data !== e.d || int'(out_chan) != e.c) begin
          n_err++;
          $display("FAIL output_word t=%0t got data=%h chan=%0d want data=%h chan=%0d",
                   $time, out_data, out_chan, e.d, e.c);
        end
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_data_a0();
    for (int i = 0; i < N; i++) in_data[i*WIDTH +: WIDTH] = 8'hA0 + 8'(i);
  endtask

  initial begin
    rst = 1'b1; rr_mode = 1'b0; sel = '0; in_valid = '1; out_ready = 1'b1;
    set_data_a0();
    // Reset with all inputs valid.
    cycles(2);
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_chan !== '0 || in_ready !== '0) begin
      n_err++;
      $display("FAIL reset_state got v=%b d=%h c=%0d r=%b want v=0 d=00 c=0 r=0000",
               out_valid, out_data, out_chan, in_ready);
    end
    @(posedge clk); #1;

    // Fixed selection of channel 2.
    rst = 1'b0; rr_mode = 1'b0; sel = 2'd2;
    cycles(6);

    // Round-robin, all channels valid, free-flowing output.
    rr_mode = 1'b1;
    cycles(8);

    // Wrap and skip: grant 2 alone (ptr -> 3), then request 0 and 2.
    in_valid = 4'b0100;
    cycles(1);
    in_valid = 4'b0101;
    cycles(4);

    // Backpressure: hold the slot for 3 cycles, then release.
    in_valid = 4'b1111;
    out_ready = 1'b0;
    cycles(3);
    out_ready = 1'b1;
    cycles(3);

    // Mid-operation reset with ptr=2 and a word in the slot.
    in_valid = 4'b0010;
    cycles(1);
    in_valid = 4'b1111;
    out_ready = 1'b0;
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
    out_ready = 1'b1;
    cycles(3);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 15) == 0) rr_mode = ~rr_mode;
      sel       = SELW'($urandom_range(0, N-1));
      in_valid  = N'($urandom);
      in_data   = (N*WIDTH)'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      rst       = ($urandom_range(0, 199) == 0);
      cycles(1);
    end

    // Drain and confirm nothing is left outstanding.
    rst = 1'b0; in_valid = '0; out_ready = 1'b1;
    cycles(3);
    n_cmp++;
    if (scb.size() != 0) begin
      n_err++;
      $display("FAIL drain_empty got %0d pending want 0", scb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/stream_mux_rr.md
STREAM_MUX_RR -- requirements
Module: stream_mux_rr

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, giving the data width per channel in bits (minimum 1).
REQ-002 The module SHALL have parameter N, default 4, giving the number of input channels (minimum 2).
REQ-003 The module SHALL have localparam SELW = $clog2(N), the index width.
REQ-004 The module SHALL have clk  input  1  system clock; all state updates on the rising edge.
REQ-005 The module SHALL have rst  input  1  reset, synchronous, active-high.
REQ-006 The module SHALL have rr_mode  input  1  1 = round-robin arbitration, 0 = fixed selection by sel.
REQ-007 The module SHALL have sel  input  SELW  channel index used when rr_mode = 0.
REQ-008 The module SHALL have in_data  input  N*WIDTH  packed channel data; channel i occupies bits [i*WIDTH +: WIDTH].
REQ-009 The module SHALL have in_valid  input  N  per-channel valid.
REQ-010 The module SHALL have in_ready  output  N  per-channel ready; combinational.
REQ-011 The module SHALL have out_data  output  WIDTH  registered output data.
REQ-012 The module SHALL have out_chan  output  SELW  registered index of the channel that supplied out_data.
REQ-013 The module SHALL have out_valid  output  1  registered output valid.
REQ-014 The module SHALL have out_ready  input  1  downstream ready.

Function
REQ-015 Transfer on any port SHALL occur only in a cycle where its valid and ready are both 1.
REQ-016 The output stage SHALL be a single register slot; slot_free = !out_valid || out_ready.
REQ-017 The grant SHALL be at most one-hot over N and SHALL be computed combinationally from in_valid, mode, sel and the rr pointer.
REQ-018 in_ready[i] SHALL be 1 iff grant[i] && slot_free; all other in_ready bits SHALL be 0.
REQ-019 With rr_mode = 0, grant[sel] SHALL be set iff sel < N and in_valid[sel] = 1; if sel >= N, no channel SHALL be granted.
REQ-020 With rr_mode = 1, the grant SHALL go to the first channel with in_valid = 1, searching from index ptr upward and wrapping from N-1 to 0.
REQ-021 After an rr-mode input transfer from channel g, ptr SHALL become g+1, or 0 if g = N-1; otherwise ptr SHALL hold its value.
REQ-022 ptr SHALL not change in fixed mode, and a mode change SHALL take effect in the same cycle without clearing ptr.
REQ-023 On an input transfer, out_data, out_chan and out_valid=1 SHALL be loaded at the next edge, giving 1-cycle latency.
REQ-024 When out_valid && out_ready and no input transfer occurs, out_valid SHALL clear at the next edge.
REQ-025 A simultaneous output drain and input load SHALL sustain 1 transfer per cycle with no bubble.
REQ-026 While out_valid && !out_ready, out_data and out_chan SHALL hold stable and every in_ready bit SHALL be 0.
REQ-027 in_ready SHALL not depend on in_data, and no bit of in_data SHALL be lost or duplicated.

Reset
REQ-028 A cycle with rst = 1 SHALL force, at the edge: out_valid = 0, out_data = 0, out_chan = 0, ptr = 0.
REQ-029 Reset SHALL win over any concurrent transfer, and a word held in the slot SHALL be discarded.
REQ-030 While rst = 1, in_ready SHALL read as 0.

Verification
REQ-031 Reset check: WIDTH=8, N=4; hold rst for 2 cycles with all in_valid=1 -> out_valid=0, in_ready=0000, out_data=0.
REQ-032 Fixed-mode check: rr_mode=0, sel=2, in_valid=1111, data ch i = 8'hA0+i, out_ready=1 -> out_data=A2 and out_chan=2 every cycle from cycle 1, and in_ready=0100.
REQ-033 Round-robin check: rr_mode=1, all valid, out_ready=1 -> out_chan sequence 0,1,2,3,0,1, one per cycle with no bubbles.
REQ-034 Wrap and skip check: rr_mode=1, ptr=3 after a grant to 2, in_valid=0101 -> the next grant is channel 0, then channel 2.
REQ-035 Backpressure check: out_ready=0 for 3 cycles with a word held -> out_data stable, in_ready=0000; on out_ready=1, the held word drains and a new word loads in the same cycle.
REQ-036 Mid-operation reset check: rst=1 asserted while out_valid=1 and ptr=2 -> at the next edge out_valid=0 and ptr=0, and the first post-reset grant is channel 0.
